// File: rtl/matmul_arbiter.sv
// matmul_arbiter: round-robin scheduler sharing one 3x3 signed 8-bit matrix multiplier
// between NUM_REQ requesters, one job in flight, single tagged response channel.
module matmul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 31,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  Clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*72-1:0] req_a,
  input  logic [NUM_REQ*72-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [71:0]           rsp_c,
  output logic                  rsp_err,
  input  logic                  rsp_ready,
  output logic                  mm_reset,
  output logic                  mm_enable,
  output logic [71:0]           mm_a,
  output logic [71:0]           mm_b,
  input  logic [71:0]           mm_c,
  input  logic                  mm_done,
  output logic                  busy
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;
  state_t state, state_nx;
  logic [ID_W-1:0] ptr, g;
  logic [CW-1:0] cnt;
  logic any, acc, tmo;
  // Descending scan so the candidate closest to ptr wins.
  always_comb begin
    g = '0;
    any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_valid[(int'(ptr) + k) % NUM_REQ]) begin
        g = ID_W'((int'(ptr) + k) % NUM_REQ);
        any = 1'b1;
      end
  end
  assign acc = state == IDLE && any;
  assign tmo = cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge Clock)
    state <= reset ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE ? (any ? RUN : IDLE) :
               state == RUN  ? ((mm_done || tmo) ? RESP : RUN) :
                               (rsp_ready ? IDLE : RESP);
  always_comb
    req_ready = acc ? NUM_REQ'(1) << g : '0;
  // Control outputs are registered from the next state so they line up with it.
  always_ff @(posedge Clock) begin
    if (reset) begin
      ptr       <= '0;
      cnt       <= '0;
      mm_reset  <= 1'b1;
      mm_enable <= 1'b0;
      mm_a      <= '0;
      mm_b      <= '0;
      rsp_c     <= '0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mm_reset  <= state_nx != RUN;
      mm_enable <= state_nx == RUN;
      rsp_valid <= state_nx == RESP;
      busy      <= state_nx != IDLE;
      if (acc) begin
        mm_a   <= req_a[int'(g)*72 +: 72];
        mm_b   <= req_b[int'(g)*72 +: 72];
        rsp_id <= g;
        ptr    <= int'(g) == NUM_REQ - 1 ? '0 : g + ID_W'(1);
        cnt    <= '0;
      end
      if (state == RUN) begin
        if (mm_done) begin
          rsp_c   <= mm_c;
          rsp_err <= 1'b0;
        end else if (tmo) begin
          rsp_c   <= '0;
          rsp_err <= 1'b1;
        end else
          cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_matmul_arbiter.sv
// tb_matmul_arbiter: self-checking bench with a behavioural multiplier stub and
// a round-robin/matrix reference model.
module tb_matmul_arbiter;
  localparam int NR = 4;
  localparam int TO = 31;
  logic Clock = 1'b0;
  logic reset;
  logic [NR-1:0] req_valid, req_ready;
  logic [NR*72-1:0] req_a, req_b;
  logic rsp_valid, rsp_err, rsp_ready, mm_reset, mm_enable, mm_done, busy;
  logic [1:0] rsp_id;
  logic [71:0] rsp_c, mm_a, mm_b, mm_c;
  int errors = 0, checks = 0, model_ptr = 0;
  bit stuck = 1'b0;
  logic [3:0] mcnt;

  always #5 Clock = ~Clock;

  matmul_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .Clock(Clock), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_c(rsp_c),
    .rsp_err(rsp_err), .rsp_ready(rsp_ready), .mm_reset(mm_reset), .mm_enable(mm_enable),
    .mm_a(mm_a), .mm_b(mm_b), .mm_c(mm_c), .mm_done(mm_done), .busy(busy)
  );

  function automatic logic [71:0] mat(input logic [71:0] a, input logic [71:0] b);
    logic [71:0] c;
    int s;
    c = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = 0;
        for (int k = 0; k < 3; k++)
          s += int'($signed(a[(i*3+k)*8 +: 8])) * int'($signed(b[(k*3+j)*8 +: 8]));
        c[(i*3+j)*8 +: 8] = s[7:0];
      end
    return c;
  endfunction

  // Multiplier stub: done after 11 enabled edges, never if stuck.
  always @(posedge Clock) begin
    if (mm_reset) begin
      mcnt <= '0;
      mm_done <= 1'b0;
      mm_c <= '0;
    end else if (mm_enable && !mm_done) begin
      mcnt <= mcnt + 4'd1;
      if (mcnt == 4'd10 && !stuck) begin
        mm_done <= 1'b1;
        mm_c <= mat(mm_a, mm_b);
      end
    end
  end

  function automatic logic [71:0] rnd72();
    logic [95:0] x;
    x = {$urandom(), $urandom(), $urandom()};
    return x[71:0];
  endfunction

  function automatic int rr_pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++)
      if (v[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic job(input logic [NR-1:0] v, input logic [71:0] a, input logic [71:0] b,
                     input logic [71:0] exp_c, input logic exp_err, input int exp_lat,
                     input bit hold, input int bp);
    int id, n;
    id = rr_pick(v, model_ptr);
    model_ptr = (id + 1) % NR;
    @(negedge Clock);
    chk("idle_busy", busy, 1'b0);
    rsp_ready = (bp == 0);
    req_valid = v;
    for (int i = 0; i < NR; i++) begin
      req_a[i*72 +: 72] = rnd72();
      req_b[i*72 +: 72] = rnd72();
    end
    req_a[id*72 +: 72] = a;
    req_b[id*72 +: 72] = b;
    #1 chk("grant", req_ready, NR'(1) << id);
    @(negedge Clock);
    if (!hold) req_valid = '0;
    chk("run_enable", mm_enable, 1'b1);
    chk("run_mm_reset", mm_reset, 1'b0);
    chk("run_busy", busy, 1'b1);
    chk("run_mm_a", mm_a, a);
    chk("run_mm_b", mm_b, b);
    chk("run_ready", req_ready, '0);
    n = 1;
    while (!rsp_valid && n < 200) begin
      @(negedge Clock);
      n++;
    end
    chk("latency", n, exp_lat);
    chk("rsp_id", rsp_id, id);
    chk("rsp_c", rsp_c, exp_c);
    chk("rsp_err", rsp_err, exp_err);
    chk("resp_mm_reset", mm_reset, 1'b1);
    chk("resp_ready", req_ready, '0);
    for (int i = 1; i <= bp; i++) begin
      @(negedge Clock);
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_c", rsp_c, exp_c);
      chk("bp_id", rsp_id, id);
      chk("bp_err", rsp_err, exp_err);
      chk("bp_ready", req_ready, '0);
      chk("bp_mm_reset", mm_reset, 1'b1);
      if (i == bp) rsp_ready = 1'b1;
    end
  endtask

  typedef struct {
    logic [NR-1:0] v;
    logic [71:0]   a;
    logic [71:0]   b;
    logic [71:0]   c;
  } vec_t;
  vec_t vt[5];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [71:0] a, b;
    int seen;
    vt[0] = '{4'b0001, 72'h010000000100000001, 72'h090807060504030201, 72'h090807060504030201};
    vt[1] = '{4'b0010, 72'h020202020202020202, 72'h030303030303030303, 72'h121212121212121212};
    vt[2] = '{4'b0100, 72'h404040404040404040, 72'h020202020202020202, 72'h808080808080808080};
    vt[3] = '{4'b1000, 72'h010000000100000001, 72'h8877665544332211FF, 72'h8877665544332211FF};
    vt[4] = '{4'b1111, 72'hFF000000FF000000FF, 72'h090807060504030201, 72'hF7F8F9FAFBFCFDFEFF};
    reset = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge Clock);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mm_reset", mm_reset, 1'b1);
    chk("rst_mm_enable", mm_enable, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_c", rsp_c, '0);
    chk("rst_rsp_id", rsp_id, '0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_mm_a", mm_a, '0);
    chk("rst_mm_b", mm_b, '0);
    chk("rst_ready", req_ready, '0);
    reset = 1'b0;
    model_ptr = 0;
    foreach (vt[i]) job(vt[i].v, vt[i].a, vt[i].b, vt[i].c, 1'b0, 13, 1'b0, 0);
    // Round-robin with all requesters held valid, starting from a fresh pointer.
    @(negedge Clock);
    reset = 1'b1;
    @(negedge Clock);
    reset = 1'b0;
    model_ptr = 0;
    for (int i = 0; i < 5; i++) begin
      a = rnd72();
      b = rnd72();
      job(4'b1111, a, b, mat(a, b), 1'b0, 13, 1'b1, 0);
    end
    a = rnd72();
    b = rnd72();
    job(4'b1111, a, b, mat(a, b), 1'b0, 13, 1'b1, 5);
    stuck = 1'b1;
    job(4'b0010, rnd72(), rnd72(), '0, 1'b1, TO + 1, 1'b0, 0);
    stuck = 1'b0;
    a = rnd72();
    b = rnd72();
    job(4'b0001, a, b, mat(a, b), 1'b0, 13, 1'b0, 0);
    for (int i = 0; i < 20; i++) begin
      a = rnd72();
      b = rnd72();
      job(NR'($urandom_range(1, 15)), a, b, mat(a, b), 1'b0, 13, 1'($urandom_range(0, 1)),
          $urandom_range(0, 3));
    end
    // Reset in the middle of a job from requester 2.
    @(negedge Clock);
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    #1 chk("mr_grant", req_ready, NR'(1) << rr_pick(4'b0100, model_ptr));
    @(negedge Clock);
    req_valid = '0;
    repeat (4) @(negedge Clock);
    reset = 1'b1;
    @(negedge Clock);
    reset = 1'b0;
    model_ptr = 0;
    chk("mr_busy", busy, 1'b0);
    chk("mr_mm_reset", mm_reset, 1'b1);
    chk("mr_mm_enable", mm_enable, 1'b0);
    chk("mr_rsp_valid", rsp_valid, 1'b0);
    chk("mr_mm_a", mm_a, '0);
    seen = 0;
    repeat (30) begin
      @(negedge Clock);
      if (rsp_valid) seen++;
    end
    chk("mr_no_rsp", seen, 0);
    a = rnd72();
    b = rnd72();
    job(4'b1111, a, b, mat(a, b), 1'b0, 13, 1'b0, 0);
    @(negedge Clock);
    chk("end_busy", busy, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
